// File: rtl/bus_datapath_pkg.sv
// Shared encodings for the single-bus datapath: bus sources, ALU operations
// and the ALU / memory FSM states.
package bus_datapath_pkg;

  typedef enum logic [3:0] {
    SRC_GPR    = 4'd0,
    SRC_PC     = 4'd1,
    SRC_MDR    = 4'd2,
    SRC_HI     = 4'd3,
    SRC_LO     = 4'd4,
    SRC_ZHI    = 4'd5,
    SRC_ZLO    = 4'd6,
    SRC_INPORT = 4'd7,
    SRC_CONST  = 4'd8
  } bus_src_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIV  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_RUN  = 2'd1,
    A_DONE = 2'd2
  } alu_state_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/alu_seq.sv
// ALU with single-cycle logic/arith/shift ops and iterative signed MUL
// (shift-add on magnitudes) and DIV (restoring on magnitudes), result into Z.
module alu_seq
  import bus_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   z,
  output logic                  carry,
  output logic                  fin_c,
  output logic                  busy_nxt_c
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned XW    = DATA_W + 1;
  localparam int unsigned ZW    = 2 * DATA_W;

  alu_state_e          state, state_d;
  alu_op_e             op_e;
  logic                iter_op;
  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   sc_res;
  logic                sc_carry;
  logic [ZW-1:0]       rot;

  logic [DATA_W-1:0]   hi, lo, mag, a_keep;
  logic [CNT_W-1:0]    cnt;
  logic                is_div, q_neg, r_neg, div0;
  logic [XW-1:0]       mul_sum, div_sh;
  logic [DATA_W-1:0]   div_sub, hi_n, lo_n, quo, rem;
  logic                div_ge;
  logic [ZW-1:0]       prod, z_fin;

  assign op_e    = alu_op_e'(op);
  assign iter_op = (op_e == OP_MUL) || (op_e == OP_DIV);
  assign sh      = b[SH_W-1:0];

  function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? ~v + DATA_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) state <= A_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d    = state;
    fin_c      = 1'b0;
    busy_nxt_c = 1'b0;
    case (state)
      A_IDLE: if (start) begin
        if (iter_op) state_d = A_RUN;
        else begin
          state_d = A_DONE;
          fin_c   = 1'b1;
        end
      end
      A_RUN: if (cnt == CNT_W'(DATA_W - 1)) begin
        state_d = A_DONE;
        fin_c   = 1'b1;
      end
      A_DONE:  state_d = A_IDLE;
      default: state_d = A_IDLE;
    endcase
    busy_nxt_c = (state_d != A_IDLE);
  end

  // Single-cycle result; the high half of Z is always zero for these ops
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    rot      = '0;
    case (op_e)
      OP_ADD:  {sc_carry, sc_res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {sc_carry, sc_res} = {1'b0, a} + {1'b0, ~b} + XW'(1);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SHR:  sc_res = a >> sh;
      OP_SHRA: sc_res = $signed(a) >>> sh;
      OP_SHL:  sc_res = a << sh;
      OP_ROR: begin
        rot    = {a, a} >> sh;
        sc_res = rot[DATA_W-1:0];
      end
      OP_ROL: begin
        rot    = {a, a} << sh;
        sc_res = rot[ZW-1:DATA_W];
      end
      OP_NEG:  sc_res = ~b + DATA_W'(1);
      OP_NOT:  sc_res = ~b;
      default: sc_res = '0;
    endcase
  end

  // One MUL or DIV iteration on the magnitude registers
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
    div_sh  = {hi, lo[DATA_W-1]};
    div_ge  = div_sh >= {1'b0, mag};
    div_sub = div_sh[DATA_W-1:0] - mag;
    if (is_div) begin
      hi_n = div_ge ? div_sub : div_sh[DATA_W-1:0];
      lo_n = {lo[DATA_W-2:0], div_ge};
    end else begin
      hi_n = mul_sum[DATA_W:1];
      lo_n = {mul_sum[0], lo[DATA_W-1:1]};
    end
    prod  = {hi_n, lo_n};
    quo   = q_neg ? ~lo_n + DATA_W'(1) : lo_n;
    rem   = r_neg ? ~hi_n + DATA_W'(1) : hi_n;
    z_fin = q_neg ? ~prod + ZW'(1) : prod;
    if (is_div) z_fin = div0 ? {a_keep, {DATA_W{1'b1}}} : {rem, quo};
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      z      <= '0;
      carry  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mag    <= '0;
      a_keep <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      div0   <= 1'b0;
    end else if (state == A_IDLE && start) begin
      if (iter_op) begin
        cnt    <= '0;
        hi     <= '0;
        is_div <= (op_e == OP_DIV);
        q_neg  <= a[DATA_W-1] ^ b[DATA_W-1];
        r_neg  <= a[DATA_W-1];
        div0   <= (b == '0);
        a_keep <= a;
        lo     <= (op_e == OP_DIV) ? mag_of(a) : mag_of(b);
        mag    <= (op_e == OP_DIV) ? mag_of(b) : mag_of(a);
      end else begin
        z     <= {{DATA_W{1'b0}}, sc_res};
        carry <= sc_carry;
      end
    end else if (state == A_RUN) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CNT_W'(1);
      if (fin_c) begin
        z     <= z_fin;
        carry <= is_div & div0;
      end
    end
  end

endmodule

// File: rtl/bus_datapath_gen.sv
// Parametrised single-bus datapath: register file, PC/IR/MAR/MDR/HI/LO/Y,
// encoded bus mux, sequential ALU and a request/acknowledge memory port.
module bus_datapath_gen
  import bus_datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned R0_ZERO  = 1,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [3:0]            bus_src,
  input  logic [IDX_W-1:0]      src_idx,
  input  logic [IDX_W-1:0]      dst_idx,
  input  logic                  reg_in,
  input  logic                  pc_in,
  input  logic                  inc_pc,
  input  logic                  ir_in,
  input  logic                  mar_in,
  input  logic                  hi_in,
  input  logic                  lo_in,
  input  logic                  y_in,
  input  logic                  mdr_in,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [3:0]            alu_op,
  input  logic                  alu_start,
  input  logic [DATA_W-1:0]     inport_data,
  input  logic [DATA_W-1:0]     const_data,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     bus_out,
  output logic [DATA_W-1:0]     ir_out,
  output logic [2*DATA_W-1:0]   z_out,
  output logic                  carry,
  output logic                  busy,
  output logic                  done
);

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] pc, mar, mdr, hi_r, lo_r, y;
  logic [DATA_W-1:0] gpr_rd;
  logic              r0_hit_rd, r0_hit_wr;
  logic              alu_fin_c, alu_busy_nxt_c;
  mem_state_e        mem_state, mem_state_d;
  logic              mem_fin_c;

  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  assign r0_hit_rd = (R0_ZERO != 0) && (src_idx == '0);
  assign r0_hit_wr = (R0_ZERO != 0) && (dst_idx == '0);
  assign gpr_rd    = r0_hit_rd ? '0 : gpr[src_idx];

  always_comb begin
    bus_out = '0;
    case (bus_src_e'(bus_src))
      SRC_GPR:    bus_out = gpr_rd;
      SRC_PC:     bus_out = pc;
      SRC_MDR:    bus_out = mdr;
      SRC_HI:     bus_out = hi_r;
      SRC_LO:     bus_out = lo_r;
      SRC_ZHI:    bus_out = z_out[2*DATA_W-1:DATA_W];
      SRC_ZLO:    bus_out = z_out[DATA_W-1:0];
      SRC_INPORT: bus_out = inport_data;
      SRC_CONST:  bus_out = const_data;
      default:    bus_out = '0;
    endcase
  end

  // MDR is owned by the memory port while a transaction is outstanding
  always_ff @(posedge clk) begin
    if (!clr) begin
      gpr    <= '{default: '0};
      pc     <= '0;
      ir_out <= '0;
      mar    <= '0;
      mdr    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      y      <= '0;
    end else begin
      if (reg_in && !r0_hit_wr) gpr[dst_idx] <= bus_out;
      if (pc_in)       pc <= bus_out;
      else if (inc_pc) pc <= pc + DATA_W'(1);
      if (ir_in)  ir_out <= bus_out;
      if (mar_in) mar    <= bus_out;
      if (hi_in)  hi_r   <= bus_out;
      if (lo_in)  lo_r   <= bus_out;
      if (y_in)   y      <= bus_out;
      if (mem_state == M_WAIT) begin
        if (mem_ack && !mem_we) mdr <= mem_rdata;
      end else if (mdr_in) begin
        mdr <= bus_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) mem_state <= M_IDLE;
    else      mem_state <= mem_state_d;
  end

  always_comb begin
    mem_state_d = mem_state;
    mem_fin_c   = 1'b0;
    case (mem_state)
      M_IDLE: if (mem_rd || mem_wr) mem_state_d = M_WAIT;
      M_WAIT: if (mem_ack) begin
        mem_state_d = M_IDLE;
        mem_fin_c   = 1'b1;
      end
      default: mem_state_d = M_IDLE;
    endcase
  end

  // Read wins when both requests arrive together
  always_ff @(posedge clk) begin
    if (!clr) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mem_req <= (mem_state_d == M_WAIT);
      mem_we  <= (mem_state_d == M_WAIT) &&
                 ((mem_state == M_WAIT) ? mem_we : !mem_rd);
      busy    <= alu_busy_nxt_c || (mem_state_d == M_WAIT);
      done    <= alu_fin_c || mem_fin_c;
    end
  end

  alu_seq #(.DATA_W(DATA_W)) u_alu (
    .clk        (clk),
    .clr        (clr),
    .start      (alu_start),
    .op         (alu_op),
    .a          (y),
    .b          (bus_out),
    .z          (z_out),
    .carry      (carry),
    .fin_c      (alu_fin_c),
    .busy_nxt_c (alu_busy_nxt_c)
  );

endmodule

// File: doc/bus_datapath_gen.md
Name: bus_datapath_gen

Overview:
- Parametrised successor to the fixed 32-bit, 16-register bus datapath.
- Contains a shared single-bus datapath with a register file, PC/IR/MAR/MDR/HI/LO/Y/Z, an encoded bus-source mux, and an ALU with multi-cycle MUL/DIV.
- Adds a memory request/acknowledge port.
- Sits under the control unit, which drives the strobes and waits on busy/done.

Parameters:
- DATA_W, 32: datapath width in bits.
- NUM_REGS, 16: general registers, power of two, 2..64.
- R0_ZERO, 1: 1 = R0 reads as zero and ignores writes.
- IDX_W, $clog2(NUM_REGS): register index width (derived).

Ports:
- clk in 1: clock.
- clr in 1: synchronous active-low reset.
- bus_src in 4: bus source select, encoded (GPR, PC, MDR, HI, LO, ZHI, ZLO, INPORT, CONST).
- src_idx in IDX_W: GPR read index.
- dst_idx in IDX_W: GPR write index.
- reg_in in 1: write bus to GPR[dst_idx].
- pc_in, inc_pc, ir_in, mar_in, hi_in, lo_in, y_in in 1 each: load strobes.
- mdr_in in 1: load MDR from bus.
- mem_rd, mem_wr in 1 each: start a memory transaction.
- alu_op in 4: ALU operation.
- alu_start in 1: start ALU, result goes to Z.
- inport_data in DATA_W: input port value.
- const_data in DATA_W: immediate source.
- mem_rdata in DATA_W: memory read data.
- mem_ack in 1: memory acknowledge.
- mem_req out 1: memory request.
- mem_we out 1: memory write enable.
- mem_addr out DATA_W: MAR value.
- mem_wdata out DATA_W: MDR value.
- bus_out out DATA_W: current bus value.
- ir_out out DATA_W: IR value.
- z_out out 2*DATA_W: Z register.
- carry out 1: ALU carry.
- busy out 1: ALU or memory operation in progress.
- done out 1: one-cycle pulse when an operation completes.

Behaviour:

Reset:
- clr low at a clk edge clears all registers, Z, carry, FSMs, mem_req, mem_we and done to 0.
- Reset mid-operation aborts it; no done pulse is produced.

Bus and loads:
- bus_out is combinational from bus_src. Unused encodings drive 0.
- GPR source reads GPR[src_idx]; R0 reads 0 when R0_ZERO=1.
- All loads capture the bus at the clk edge while the strobe is high.
- inc_pc adds 1 to PC (mod 2^DATA_W). If pc_in and inc_pc are both high, pc_in wins.

ALU FSM (A_IDLE, A_RUN, A_DONE):
- Operands: A = Y, B = bus, both sampled at the alu_start edge.
- Single-cycle ops: ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
  - A_IDLE -> A_DONE.
  - Z = {0, result}, where the high half is the sign-extended result for NEG/SUB? No: the high half is 0 for every single-cycle op.
  - carry is the ADD/SUB carry-out and is cleared by the other ops.
  - Shift amount = B[$clog2(DATA_W)-1:0].
- MUL (signed, shift-add):
  - A_RUN for DATA_W cycles, then A_DONE.
  - Z = full 2*DATA_W product.
- DIV (signed, restoring):
  - A_RUN for DATA_W cycles.
  - Z = {remainder, quotient}.
  - Divide by zero: Z = {A, all-ones}, carry = 1.
- A_DONE: Z is written, done pulses for one cycle, then A_IDLE.
- Latency: single-cycle op done at start+1; MUL/DIV done at start+DATA_W+1.
- alu_start while busy is ignored. Z and carry are unchanged until A_DONE.

Memory FSM (M_IDLE, M_WAIT):
- mem_rd or mem_wr in M_IDLE -> M_WAIT.
  - mem_req = 1; mem_we = 1 for a write.
  - mem_addr = MAR; mem_wdata = MDR.
- Hold in M_WAIT until mem_ack.
  - Read: MDR <= mem_rdata.
  - Then done pulses and the FSM returns to M_IDLE.
- If mem_rd and mem_wr are both high, the read wins.
- A new request while in M_WAIT is ignored.
- mdr_in is ignored during M_WAIT.
- mem_ack in M_IDLE is ignored.

Status:
- busy = (ALU FSM != A_IDLE) | (memory FSM == M_WAIT).
- If the ALU and memory both complete in the same cycle, a single done pulse is produced.

Decomposition:
- Package bus_datapath_pkg holds:
  - bus_src_e enum (GPR=0, PC=1, MDR=2, HI=3, LO=4, ZHI=5, ZLO=6, INPORT=7, CONST=8).
  - alu_op_e enum (ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, MUL=9, DIV=10, NEG=11, NOT=12).
  - FSM state enums.
- Sub-module alu_seq (parametrised by DATA_W) owns the ALU FSM, the MUL/DIV iteration and the carry flag.
- The top level keeps the registers, the bus mux and the memory FSM.

Test Plan:
1. Reset and R0:
   - clr=0 for 2 cycles, then reg_in with dst_idx=0 and bus=CONST 0x55.
   - Expect every bus source to read 0 and GPR0 to stay 0.
2. Move and ADD:
   - Load R3=7 and R4=5, Y<=R3, then alu_start ADD with bus=R4.
   - Expect done at +1, z_out=12, carry=0.
   - Repeat with 0xFFFFFFFF+1: expect Z low half 0, carry=1.
3. MUL:
   - Y=-3, bus=6, alu_start MUL.
   - Expect busy for 33 cycles, done at +33, z_out = 64'hFFFF_FFFF_FFFF_FFEE.
   - A second alu_start at +5 is ignored.
4. DIV:
   - Y=17, bus=5: expect Z={2,3}.
   - Y=9, bus=0: expect Z={9,0xFFFFFFFF}, carry=1.
5. Memory:
   - MAR=0x40, mem_rd; hold mem_ack low for 3 cycles, then return mem_rdata=0xDEADBEEF.
   - Expect mem_req held high, MDR=0xDEADBEEF, one done pulse.
   - A write drives mem_we=1 with mem_wdata=MDR.
6. Reset mid-MUL:
   - clr low at cycle 10 of a MUL.
   - Expect busy=0, Z=0, no done pulse, and the next ADD working normally.
   - Parameter sweep: DATA_W=16, NUM_REGS=8; MUL latency is 17 cycles.
